// File: rtl/dot_product_driver_if.sv
// rtl/dot_product_driver_if.sv - command, operand and multiplier handshake bundle for dot_product_driver
interface dot_product_driver_if #(
  parameter int w  = 8,
  parameter int n  = 4,
  parameter int aw = 16
);
  logic           start;
  logic [n*w-1:0] vec_a;
  logic [n*w-1:0] vec_b;
  logic [w-1:0]   mul_input_a;
  logic           mul_input_a_stb;
  logic           mul_input_a_ack;
  logic [w-1:0]   mul_input_b;
  logic           mul_input_b_stb;
  logic           mul_input_b_ack;
  logic [w-1:0]   mul_output_z;
  logic           mul_output_z_stb;
  logic           mul_output_z_ack;
  logic [aw-1:0]  result;
  logic           done;
  logic           busy;

  modport master (
    input  start, vec_a, vec_b,
    input  mul_input_a_ack, mul_input_b_ack, mul_output_z, mul_output_z_stb,
    output mul_input_a, mul_input_a_stb, mul_input_b, mul_input_b_stb,
    output mul_output_z_ack, result, done, busy
  );

  modport slave (
    output start, vec_a, vec_b,
    output mul_input_a_ack, mul_input_b_ack, mul_output_z, mul_output_z_stb,
    input  mul_input_a, mul_input_a_stb, mul_input_b, mul_input_b_stb,
    input  mul_output_z_ack, result, done, busy
  );
endinterface

// File: rtl/dot_product_driver.sv
// rtl/dot_product_driver.sv - sequences vector elements through an external handshaked multiplier and accumulates a dot product
module dot_product_driver #(
  parameter int w  = 8,
  parameter int n  = 4,
  parameter int aw = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dot_product_driver_if.master bus
);
  localparam int iw = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_Z, DONE} state_t;

  state_t         state;
  logic [iw-1:0]  idx;
  logic [aw-1:0]  acc;
  logic [n*w-1:0] a_lat;
  logic [n*w-1:0] b_lat;

  logic [aw-1:0]  acc_next;
  logic [iw-1:0]  idx_next;
  logic           a_clear;
  logic           b_clear;
  logic           last;

  // A channel counts as finished once its stb is already low or it transfers on this edge.
  always_comb begin
    acc_next = acc + aw'($signed(bus.mul_output_z));
    idx_next = idx + 1'b1;
    a_clear  = !bus.mul_input_a_stb || bus.mul_input_a_ack;
    b_clear  = !bus.mul_input_b_stb || bus.mul_input_b_ack;
    last     = (idx == iw'(n - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      idx                  <= '0;
      acc                  <= '0;
      a_lat                <= '0;
      b_lat                <= '0;
      bus.mul_input_a      <= '0;
      bus.mul_input_a_stb  <= 1'b0;
      bus.mul_input_b      <= '0;
      bus.mul_input_b_stb  <= 1'b0;
      bus.mul_output_z_ack <= 1'b0;
      bus.result           <= '0;
      bus.done             <= 1'b0;
      bus.busy             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_lat               <= bus.vec_a;
            b_lat               <= bus.vec_b;
            acc                 <= '0;
            bus.result          <= '0;
            idx                 <= '0;
            bus.mul_input_a     <= bus.vec_a[w-1:0];
            bus.mul_input_b     <= bus.vec_b[w-1:0];
            bus.mul_input_a_stb <= 1'b1;
            bus.mul_input_b_stb <= 1'b1;
            bus.busy            <= 1'b1;
            state               <= SEND;
          end
        end

        SEND: begin
          if (bus.mul_input_a_stb && bus.mul_input_a_ack) begin
            bus.mul_input_a_stb <= 1'b0;
          end
          if (bus.mul_input_b_stb && bus.mul_input_b_ack) begin
            bus.mul_input_b_stb <= 1'b0;
          end
          if (a_clear && b_clear) begin
            bus.mul_output_z_ack <= 1'b1;
            state                <= WAIT_Z;
          end
        end

        WAIT_Z: begin
          if (bus.mul_output_z_stb) begin
            bus.mul_output_z_ack <= 1'b0;
            acc                  <= acc_next;
            if (last) begin
              bus.result <= acc_next;
              bus.done   <= 1'b1;
              state      <= DONE;
            end else begin
              idx                 <= idx_next;
              bus.mul_input_a     <= a_lat[idx_next*w +: w];
              bus.mul_input_b     <= b_lat[idx_next*w +: w];
              bus.mul_input_a_stb <= 1'b1;
              bus.mul_input_b_stb <= 1'b1;
              state               <= SEND;
            end
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_driver.sv
// tb/tb_dot_product_driver.sv - directed self-checking bench for dot_product_driver with a behavioural multiplier responder
module tb_dot_product_driver;
  localparam int w  = 8;
  localparam int n  = 4;
  localparam int aw = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_product_driver_if #(.w(w), .n(n), .aw(aw)) bus ();
  dot_product_driver #(.w(w), .n(n), .aw(aw)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  int a_dly = 0, b_dly = 0, z_dly = 0;
  bit spur = 1'b0;
  int cnt_a = 0, cnt_b = 0, cnt_z = 0;
  logic [7:0] op_a = '0, op_b = '0;
  int pa, pb, prod;
  int z_xfers = 0, done_cnt = 0;
  bit b_drop_seen = 1'b0;

  // Multiplier model: acks after a programmable number of cycles, returns the low w bits of the signed product.
  initial begin
    bus.mul_input_a_ack  = 1'b1;
    bus.mul_input_b_ack  = 1'b1;
    bus.mul_output_z_stb = 1'b0;
    bus.mul_output_z     = '0;
    forever begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.mul_input_a_stb) begin
        bus.mul_input_a_ack = (cnt_a >= a_dly);
        if (bus.mul_input_a_ack) op_a = bus.mul_input_a;
        cnt_a++;
      end else begin
        cnt_a = 0;
        bus.mul_input_a_ack = (a_dly == 0);
      end
      if (bus.mul_input_b_stb) begin
        bus.mul_input_b_ack = (cnt_b >= b_dly);
        if (bus.mul_input_b_ack) op_b = bus.mul_input_b;
        cnt_b++;
      end else begin
        cnt_b = 0;
        bus.mul_input_b_ack = (b_dly == 0);
      end
      if (bus.mul_input_a_stb && !bus.mul_input_b_stb) b_drop_seen = 1'b1;
      if (bus.mul_output_z_ack) begin
        pa   = $signed(op_a);
        pb   = $signed(op_b);
        prod = pa * pb;
        bus.mul_output_z_stb = (cnt_z >= z_dly);
        bus.mul_output_z     = prod[7:0];
        if (bus.mul_output_z_stb) z_xfers++;
        cnt_z++;
      end else begin
        cnt_z = 0;
        bus.mul_output_z_stb = spur;
        bus.mul_output_z     = spur ? 8'h7F : 8'h00;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int e0, input int e1, input int e2, input int e3);
    return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  function automatic logic [31:0] outs_now();
    return {bus.mul_input_a, bus.mul_input_b, bus.mul_input_a_stb, bus.mul_input_b_stb,
            bus.mul_output_z_ack, bus.done, bus.busy};
  endfunction

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     output int lat, output logic [31:0] snap, output bit timeout);
    @(negedge clk);
    bus.vec_a = a;
    bus.vec_b = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat  = 1;
    snap = {13'd0, bus.busy, bus.mul_input_a_stb, bus.mul_input_b_stb, bus.mul_input_a, bus.mul_input_b};
    while (!bus.done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    timeout = !bus.done;
  endtask

  int lat;
  logic [31:0] snap;
  bit to;
  int guard;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.vec_a = '0;
    bus.vec_b = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs_now(), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    rst = 1'b0;

    // plain run, always-ready multiplier
    done_cnt = 0;
    run(pack(1, 2, 3, 4), pack(5, 6, 7, 8), lat, snap, to);
    check("basic_first_send", snap, {13'd0, 1'b1, 1'b1, 1'b1, 8'd1, 8'd5});
    check("basic_timeout", 32'(to), 32'd0);
    check("basic_latency", 32'(lat), 32'd9);
    check("basic_result", 32'(bus.result), 32'h0046);
    @(negedge clk);
    check("basic_done_pulse", 32'(done_cnt), 32'd1);
    check("basic_idle_after", {bus.busy, bus.done}, 32'd0);

    // negative elements
    run(pack(-3, -4, 0, 0), pack(5, 5, 0, 0), lat, snap, to);
    check("neg_result", 32'(bus.result), 32'hFFDD);

    // slow multiplier: A waits 2, B waits 1, Z waits 3
    a_dly = 2; b_dly = 1; z_dly = 3;
    b_drop_seen = 1'b0; z_xfers = 0; done_cnt = 0;
    run(pack(1, 2, 3, 4), pack(5, 6, 7, 8), lat, snap, to);
    check("slow_timeout", 32'(to), 32'd0);
    check("slow_result", 32'(bus.result), 32'h0046);
    check("slow_b_drop_a_held", 32'(b_drop_seen), 32'd1);
    check("slow_z_transfers", 32'(z_xfers), 32'd4);
    @(negedge clk);
    check("slow_done_pulse", 32'(done_cnt), 32'd1);
    a_dly = 0; b_dly = 0; z_dly = 0;

    // start re-pulsed in SEND and DONE, operands changed after latch
    done_cnt = 0;
    @(negedge clk);
    bus.vec_a = pack(1, 2, 3, 4);
    bus.vec_b = pack(5, 6, 7, 8);
    bus.start = 1'b1;
    @(negedge clk);
    check("repulse_in_send", {bus.busy, bus.mul_input_a_stb}, 32'd3);
    @(negedge clk);
    bus.start = 1'b0;
    bus.vec_a = pack(9, 9, 9, 9);
    bus.vec_b = pack(-1, -1, -1, -1);
    guard = 0;
    while (!bus.done && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("repulse_done_seen", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("repulse_single_done", 32'(done_cnt), 32'd1);
    check("repulse_stays_idle", 32'(bus.busy), 32'd0);
    check("repulse_result_held", 32'(bus.result), 32'h0046);

    // reset while waiting for the third product
    z_dly = 3; z_xfers = 0; done_cnt = 0;
    @(negedge clk);
    bus.vec_a = pack(1, 2, 3, 4);
    bus.vec_b = pack(5, 6, 7, 8);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (!(z_xfers == 2 && bus.mul_output_z_ack) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("rst_reached_wait_z", 32'(bus.mul_output_z_ack), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", outs_now(), 32'd0);
    check("rst_mid_result", 32'(bus.result), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    z_dly = 0;
    repeat (2) @(negedge clk);
    check("rst_no_done", 32'(done_cnt), 32'd0);
    run(pack(1, 1, 1, 1), pack(2, 2, 2, 2), lat, snap, to);
    check("rst_restart_latency", 32'(lat), 32'd9);
    check("rst_restart_result", 32'(bus.result), 32'h0008);

    // spurious product strobes outside WAIT_Z
    spur = 1'b1;
    repeat (3) @(negedge clk);
    run(pack(1, 2, 3, 4), pack(5, 6, 7, 8), lat, snap, to);
    check("spur_latency", 32'(lat), 32'd9);
    check("spur_result", 32'(bus.result), 32'h0046);
    repeat (3) @(negedge clk);
    check("spur_idle_result", 32'(bus.result), 32'h0046);
    spur = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dot_product_driver.md
DOT_PRODUCT_DRIVER -- requirements
Module: dot_product_driver

Interface
REQ-001 Parameter w, default 8, operand and multiplier-result width in bits.
REQ-002 Parameter n, default 4, vector length (elements per dot product), n >= 1.
REQ-003 Parameter aw, default 16, accumulator/result width, aw >= w.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request a dot product; sampled only in IDLE.
REQ-007 vec_a  input  n*w  operand vector A; element i at bits [i*w +: w], two's complement.
REQ-008 vec_b  input  n*w  operand vector B, same packing as vec_a.
REQ-009 mul_input_a  output  w  operand A element to the multiplier.
REQ-010 mul_input_a_stb  output  1  mul_input_a valid.
REQ-011 mul_input_a_ack  input  1  multiplier accepts A.
REQ-012 mul_input_b  output  w  operand B element to the multiplier.
REQ-013 mul_input_b_stb  output  1  mul_input_b valid.
REQ-014 mul_input_b_ack  input  1  multiplier accepts B.
REQ-015 mul_output_z  input  w  product from the multiplier, two's complement.
REQ-016 mul_output_z_stb  input  1  mul_output_z valid.
REQ-017 mul_output_z_ack  output  1  driver accepts Z.
REQ-018 result  output  aw  accumulated dot product, two's complement.
REQ-019 done  output  1  one-cycle pulse, result final.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 Transfer on any channel SHALL occur on a rising edge where that channel's stb and ack are both high.
REQ-022 FSM states SHALL be IDLE, SEND, WAIT_Z, DONE.
REQ-023 IDLE + start=1: latch vec_a/vec_b, clear accumulator and result to 0, index=0, go SEND next cycle; start=0 stays IDLE.
REQ-024 SEND entry: mul_input_a/mul_input_b driven with element[index] of latched vectors, both stb high.
REQ-025 In SEND each stb SHALL drop the cycle after its own transfer and stay low; the other channel continues independently.
REQ-026 SEND -> WAIT_Z on the edge where the last outstanding of A/B transfers (both may transfer same edge).
REQ-027 In WAIT_Z mul_output_z_ack SHALL be 1; it SHALL be 0 in all other states.
REQ-028 On Z transfer: accumulator += sign-extend(mul_output_z) to aw bits, modulo 2^aw (wrap, no saturation).
REQ-029 On Z transfer with index < n-1: index+1, go SEND; with index = n-1: go DONE.
REQ-030 DONE: done=1 for exactly one cycle, result = final accumulator, go IDLE next cycle.
REQ-031 result SHALL hold its value from DONE until the next accepted start.
REQ-032 start outside IDLE (incl. DONE) SHALL be ignored; vec_a/vec_b changes after latch SHALL not affect the operation.
REQ-033 mul_output_z_stb outside WAIT_Z SHALL be ignored (no accumulation).
REQ-034 Latency with always-high acks/stb: done asserted 2*n+1 cycles after the start edge.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, index=0, accumulator=0, and all outputs to 0 (mul_input_a, mul_input_b, all stb, mul_output_z_ack, result, done, busy).
REQ-036 Reset mid-operation SHALL abandon the operation with no done pulse; first start after release SHALL behave as from power-up.

Verification (w=8, n=4, aw=16, multiplier model returns low w bits of signed product)
REQ-037 Acks and z_stb always 1; a={1,2,3,4}, b={5,6,7,8}, start one cycle -> done on cycle 9 after start edge, result=70 (0x0046), busy low after.
REQ-038 a={-3,-4,0,0}, b={5,5,0,0} -> result=-35 (0xFFDD).
REQ-039 A ack delayed 2 cycles, B ack 1 cycle, Z stb delayed 3 cycles per element -> mul_input_b_stb drops after its transfer while A stb held; result=70; no double-count.
REQ-040 start pulsed during SEND and during DONE -> ignored; single done pulse; result unchanged until next IDLE start.
REQ-041 rst asserted in WAIT_Z of element 2 -> all outputs 0 same cycle, no done; restart with a={1,1,1,1}, b={2,2,2,2} -> result=8.
REQ-042 Spurious mul_output_z_stb=1 with value 0x7F during IDLE and SEND -> accumulator unaffected; result matches REQ-037.
